md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 153 +++++++++++++++
 tb/tb_md_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl -- multiply/divide unit controller with HI/LO registers.
//
// Starts mult/multu (5 busy cycles) and div/divu (10 busy cycles) from the
// E stage. The result is computed at accept time and held in a pending
// register until the countdown expires, then committed to HI/LO. mthi/mtlo
// write HI/LO directly. mfhi/mflo read only committed HI/LO.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   en     in   E-stage MD instruction valid
//   req    in   exception/interrupt flush of the E-stage instruction
//   MDop   in   [3:0] 0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,
//                     7 mthi,8 mtlo, 9-15 none
//   A, B   in   [31:0] rs / rt operands
//   out    out  [31:0] mfhi/mflo read data (0 for any other MDop)
//   busy   out  operation in flight (registered)
//   done   out  one-cycle pulse after HI/LO commit
//
// Build option: MD_DIVZERO_HOLD_EN -- when defined, div/divu by zero does not
// start the unit; it only pulses done and leaves HI/LO untouched.
module md_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        req,
    input  logic [3:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi, lo, p_hi, p_lo;
    logic        accept;
    logic [63:0] prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    assign accept = en & ~req & (state == IDLE);

    // Sign-extending to 64 bits makes the low 64 bits of the product the
    // correct two's-complement signed result.
    always_comb begin
        if (MDop == OP_MULT) prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        else                 prod = {32'b0, A} * {32'b0, B};
    end

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign. |0x80000000| fits as unsigned, so
    // 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    always_comb begin
        a_neg = (MDop == OP_DIV) & A[31];
        b_neg = (MDop == OP_DIV) & B[31];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
        q_mag = '0;
        r_mag = '0;
        quo   = '1;
        rem   = A;
        if (B != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
            rem   = a_neg ? -r_mag : r_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            hi    <= '0;
            lo    <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    case (MDop)
                        OP_MULT, OP_MULTU: begin
                            state        <= MUL;
                            cnt          <= 4'd4;
                            {p_hi, p_lo} <= prod;
                            busy         <= 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MD_DIVZERO_HOLD_EN
                            if (B == 32'd0) begin
                                done <= 1'b1;
                            end else begin
                                state <= DIV;
                                cnt   <= 4'd9;
                                p_hi  <= rem;
                                p_lo  <= quo;
                                busy  <= 1'b1;
                            end
`else
                            state <= DIV;
                            cnt   <= 4'd9;
                            p_hi  <= rem;
                            p_lo  <= quo;
                            busy  <= 1'b1;
`endif
                        end
                        OP_MTHI: hi <= A;
                        OP_MTLO: lo <= A;
                        default: ;
                    endcase
                end
                MUL, DIV: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        hi    <= p_hi;
                        lo    <= p_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (MDop)
            OP_MFHI: out = hi;
            OP_MFLO: out = lo;
            default: out = '0;
        endcase
    end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl -- self-checking bench for md_ctrl: directed vector table,
// hand-written flush/reset sequences, and random ops against an arithmetic
// reference model.
module tb_md_ctrl;
    logic        clk = 1'b0;
    logic        reset, en, req;
    logic [3:0]  MDop;
    logic [31:0] A, B, out;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    md_ctrl dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .MDop(MDop),
        .A(A), .B(B), .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        int          nb, nd;
        logic [31:0] hi, lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic r);
        en = 1'b1; req = r; MDop = op; A = a; B = b;
        tick();
        en = 1'b0; req = 1'b0; MDop = 4'd0; A = '0; B = '0;
    endtask

    // Counts busy samples from now until busy drops (bounded), and done pulses.
    task automatic wait_idle(output int nb, output int nd);
        nb = 0; nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) nd++;
            if (!busy) break;
            nb++;
            tick();
        end
    endtask

    task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
        MDop = 4'd5; #1; h = out;
        MDop = 4'd6; #1; l = out;
        MDop = 4'd0;
    endtask

    // Reference: what an architecturally correct MD unit does per instruction.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic r, inout logic [31:0] h, inout logic [31:0] l,
                         output int nb, output int nd);
        longint      sa, sb, sp;
        logic [63:0] up;
        nb = 0; nd = 0;
        if (r) return;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin sp = sa * sb; {h, l} = 64'(sp); nb = 5; nd = 1; end
            4'd2: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; nb = 5; nd = 1; end
            4'd3, 4'd4: begin
                nd = 1;
                if (b == 0) begin
`ifdef MD_DIVZERO_HOLD_EN
                    nb = 0;
`else
                    nb = 10; l = 32'hFFFFFFFF; h = a;
`endif
                end else begin
                    nb = 10;
                    if (op == 4'd3) begin l = 32'(sa / sb); h = 32'(sa % sb); end
                    else begin l = a / b; h = a % b; end
                end
            end
            4'd7: h = a;
            4'd8: l = a;
            default: ;
        endcase
    endtask

    vec_t        tbl[9];
    int          nb, nd, enb, end_;
    logic [31:0] rh, rl, mh, ml;

    initial begin
        reset = 1'b1; en = 1'b0; req = 1'b0; MDop = 4'd0; A = '0; B = '0;
        tick(); tick();
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        read_hl(rh, rl);
        check("reset_hi", rh, 32'd0);
        check("reset_lo", rl, 32'd0);

        tbl[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        5,  1, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1] = '{4'd4, 32'd100,      32'd7,        10, 1, 32'd2,        32'd14};
        tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        10, 1, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1, 32'd0,        32'h80000000};
        tbl[4] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  1, 32'hFFFFFFFE, 32'h00000001};
        tbl[5] = '{4'd7, 32'h1234,     32'd0,        0,  0, 32'h1234,     32'h00000001};
        tbl[6] = '{4'd8, 32'hABCD,     32'd0,        0,  0, 32'h1234,     32'hABCD};
`ifdef MD_DIVZERO_HOLD_EN
        tbl[7] = '{4'd3, 32'h55,       32'd0,        0,  1, 32'h1234,     32'hABCD};
`else
        tbl[7] = '{4'd3, 32'h55,       32'd0,        10, 1, 32'h55,       32'hFFFFFFFF};
`endif
        tbl[8] = '{4'd1, 32'd7,        32'hFFFFFFFD, 5,  1, 32'hFFFFFFFF, 32'hFFFFFFEB};

        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
            wait_idle(nb, nd);
            check($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'(tbl[i].nb));
            check($sformatf("vec%0d_done_pulses", i), 32'(nd), 32'(tbl[i].nd));
            read_hl(rh, rl);
            check($sformatf("vec%0d_hi", i), rh, tbl[i].hi);
            check($sformatf("vec%0d_lo", i), rl, tbl[i].lo);
        end

        // divu in flight; flushes and a stalled-out mthi must not disturb it,
        // and the pending result must stay hidden until commit.
        issue(4'd4, 32'd100, 32'd7, 1'b0);
        en = 1'b1; req = 1'b1; MDop = 4'd7; A = 32'hDEAD;
        tick(); tick();
        req = 1'b0;
        tick();
        en = 1'b0; A = '0; MDop = 4'd5;
        #1;
        check("inflight_hi_hidden", out, 32'hFFFFFFFF);
        MDop = 4'd6;
        #1;
        check("inflight_lo_hidden", out, 32'hFFFFFFEB);
        MDop = 4'd0;
        wait_idle(nb, nd);
        check("req_div_busy_left", 32'(nb), 32'd7);
        check("req_div_done", 32'(nd), 32'd1);
        read_hl(rh, rl);
        check("req_div_hi", rh, 32'd2);
        check("req_div_lo", rl, 32'd14);

        // mthi flushed on its own cycle
        issue(4'd7, 32'h1234, 32'd0, 1'b1);
        wait_idle(nb, nd);
        check("flush_mthi_busy", 32'(nb), 32'd0);
        check("flush_mthi_done", 32'(nd), 32'd0);
        read_hl(rh, rl);
        check("flush_mthi_hi", rh, 32'd2);

        // reset on busy cycle 3 of a mult
        issue(4'd1, 32'd3, 32'd5, 1'b0);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) nd++;
            tick();
        end
        check("rst_mid_no_done_later", 32'(nd), 32'd0);
        read_hl(rh, rl);
        check("rst_mid_hi", rh, 32'd0);
        check("rst_mid_lo", rl, 32'd0);

        // reset on the commit edge wins over commit
        issue(4'd1, 32'd3, 32'd5, 1'b0);
        tick(); tick(); tick(); tick();
        check("pre_commit_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_commit_busy", 32'(busy), 32'd0);
        check("rst_commit_done", 32'(done), 32'd0);
        read_hl(rh, rl);
        check("rst_commit_hi", rh, 32'd0);
        check("rst_commit_lo", rl, 32'd0);

        // random ops against the reference model
        mh = '0; ml = '0;
        for (int i = 0; i < 80; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            logic        r;
            op = 4'($urandom_range(1, 9));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 17));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h80000000;
            r = ($urandom_range(0, 7) == 0);
            if (op == 4'd5 || op == 4'd6) begin
                MDop = op; en = 1'b1; req = r;
                #1;
                check($sformatf("rnd%0d_read", i), out, (op == 4'd5) ? mh : ml);
                en = 1'b0; req = 1'b0; MDop = 4'd0;
                tick();
            end else begin
                issue(op, a, b, r);
                wait_idle(nb, nd);
                model(op, a, b, r, mh, ml, enb, end_);
                check($sformatf("rnd%0d_op%0d_busy", i, op), 32'(nb), 32'(enb));
                check($sformatf("rnd%0d_op%0d_done", i, op), 32'(nd), 32'(end_));
                read_hl(rh, rl);
                check($sformatf("rnd%0d_op%0d_hi", i, op), rh, mh);
                check($sformatf("rnd%0d_op%0d_lo", i, op), rl, ml);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
